// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the 9-bit core: fetch, execute, memory, writeback.
// Strobes are decoded from the registered state; counters and Error are registered.
module core_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             BranchEn,
    input  logic             RegWrEn,
    input  logic             MemWrEn,
    input  logic             LoadInst,
    input  logic             Ack,
    input  logic             BranchTaken,
    input  logic             MemReady,
    output logic             PcClear,
    output logic             IrLoad,
    output logic             PcEn,
    output logic             PcLoadTarget,
    output logic             RegWrStrobe,
    output logic             MemReq,
    output logic             MemWe,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [CNT_W-1:0] CycleCount,
    output logic [CNT_W-1:0] InstCount
);

    localparam bit TO_EN  = (MEM_TIMEOUT > 0);
    localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TO_LAST);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic              arm_q;
    logic              memwe_q, memwe_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  inst_q, inst_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // arm_q keeps the first cycle after reset release free of any strobe or transition
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            arm_q   <= 1'b0;
            memwe_q <= 1'b0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= 1'b1;
            memwe_q <= memwe_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        memwe_d      = memwe_q;
        wait_d       = wait_q;
        err_d        = err_q;
        cyc_d        = cyc_q;
        inst_d       = inst_q;
        PcClear      = 1'b0;
        IrLoad       = 1'b0;
        PcEn         = 1'b0;
        PcLoadTarget = 1'b0;
        RegWrStrobe  = 1'b0;
        MemReq       = 1'b0;
        MemWe        = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start && arm_q) begin
                    PcClear = 1'b1;
                    err_d   = 1'b0;
                    cyc_d   = '0;
                    inst_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                IrLoad  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Halt opcode also decodes as a register write; Ack must win
                if (Ack) begin
                    state_d = S_HALT;
                end else if (MemWrEn || LoadInst) begin
                    memwe_d = MemWrEn;
                    wait_d  = '0;
                    state_d = S_MEM;
                end else if (BranchEn) begin
                    PcEn         = 1'b1;
                    PcLoadTarget = BranchTaken;
                    state_d      = S_FETCH;
                end else begin
                    RegWrStrobe = RegWrEn;
                    PcEn        = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEM: begin
                MemReq = 1'b1;
                MemWe  = memwe_q;
                if (MemReady) begin
                    if (memwe_q) begin
                        PcEn    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (TO_EN && wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else if (TO_EN) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                RegWrStrobe = 1'b1;
                PcEn        = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (Busy) cyc_d = sat_inc(cyc_q);
        if (PcEn) inst_d = sat_inc(inst_q);
    end

    assign Busy       = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                        (state_q == S_MEM)   || (state_q == S_WB);
    assign Done       = (state_q == S_HALT);
    assign Error      = err_q;
    assign CycleCount = cyc_q;
    assign InstCount  = inst_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-instruction cycle-trace model feeds one
// compare loop, plus literal end-of-program checks on counts and flags.
module tb_core_sequencer;

    localparam int CNT_W  = 4;
    localparam int MEM_TO = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic Clk = 1'b0;
    logic Reset_n, Start, BranchEn, RegWrEn, MemWrEn, LoadInst, Ack, BranchTaken, MemReady;
    logic PcClear, IrLoad, PcEn, PcLoadTarget, RegWrStrobe, MemReq, MemWe, Busy, Done, Error;
    logic [CNT_W-1:0] CycleCount, InstCount;

    core_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .BranchEn(BranchEn),
        .RegWrEn(RegWrEn), .MemWrEn(MemWrEn), .LoadInst(LoadInst), .Ack(Ack),
        .BranchTaken(BranchTaken), .MemReady(MemReady), .PcClear(PcClear),
        .IrLoad(IrLoad), .PcEn(PcEn), .PcLoadTarget(PcLoadTarget),
        .RegWrStrobe(RegWrStrobe), .MemReq(MemReq), .MemWe(MemWe), .Busy(Busy),
        .Done(Done), .Error(Error), .CycleCount(CycleCount), .InstCount(InstCount)
    );

    always #5 Clk = ~Clk;

    // One clock cycle: inputs to apply and outputs the rules demand
    typedef struct packed {
        bit start, ack, memwr, load, br, regwr, taken, mrdy;
        bit e_pcclr, e_ir, e_pcen, e_plt, e_rw, e_mreq, e_mwe, e_busy, e_done;
        bit clr, to_err;
    } cyc_t;

    typedef enum {K_ALU, K_NOP, K_BR, K_ST, K_LD, K_HALT, K_LDTO} kind_t;

    cyc_t q[$];
    int total = 0, bad = 0, step = 0;
    bit m_halted = 0, merr = 0;
    int mcyc = 0, minst = 0;
    int t_memreq, t_rw, t_pcen, t_plt, t_pcclr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0d expected=%0d", name, step, act, exp);
        end
    endtask

    task automatic tally_clear();
        t_memreq = 0; t_rw = 0; t_pcen = 0; t_plt = 0; t_pcclr = 0;
    endtask

    function automatic cyc_t busy_noise();
        cyc_t r = '0;
        r.start = 1; r.ack = 1; r.memwr = 1; r.load = 1; r.br = 1;
        r.regwr = 1; r.taken = 1; r.mrdy = 1; r.e_busy = 1;
        return r;
    endfunction

    task automatic push_arm();
        cyc_t r = '0;
        r.start = 1;
        q.push_back(r);
    endtask

    task automatic push_start();
        cyc_t r = '0;
        r.start = 1; r.e_pcclr = 1; r.e_done = m_halted; r.clr = 1;
        m_halted = 0;
        q.push_back(r);
    endtask

    task automatic push_idle(int n);
        cyc_t r = '0;
        r.e_done = m_halted;
        repeat (n) q.push_back(r);
    endtask

    task automatic push_instr(kind_t k, int w = 0, bit t = 0);
        cyc_t r;
        r = busy_noise(); r.e_ir = 1;
        q.push_back(r);
        r = busy_noise();
        r.ack = 0; r.memwr = 0; r.load = 0; r.br = 0; r.regwr = 0; r.taken = t;
        case (k)
            K_ALU:  begin r.regwr = 1; r.taken = 1; r.e_pcen = 1; r.e_rw = 1; end
            K_NOP:  r.e_pcen = 1;
            K_BR:   begin r.br = 1; r.regwr = 1; r.e_pcen = 1; r.e_plt = t; end
            K_ST:   begin r.memwr = 1; r.load = 1; r.br = 1; end
            K_LD, K_LDTO: begin r.load = 1; r.br = 1; r.regwr = 1; end
            K_HALT: begin r.ack = 1; r.regwr = 1; r.memwr = 1; r.load = 1; r.br = 1; end
            default: ;
        endcase
        q.push_back(r);
        if (k == K_HALT) m_halted = 1;
        if (k == K_ST || k == K_LD) begin
            for (int i = 0; i < w; i++) begin
                r = busy_noise(); r.mrdy = 0; r.e_mreq = 1; r.e_mwe = (k == K_ST);
                q.push_back(r);
            end
            r = busy_noise(); r.e_mreq = 1; r.e_mwe = (k == K_ST); r.e_pcen = (k == K_ST);
            q.push_back(r);
            if (k == K_LD) begin
                r = busy_noise(); r.mrdy = 0; r.e_rw = 1; r.e_pcen = 1;
                q.push_back(r);
            end
        end
        if (k == K_LDTO) begin
            for (int i = 0; i < MEM_TO; i++) begin
                r = busy_noise(); r.mrdy = 0; r.e_mreq = 1;
                r.to_err = (i == MEM_TO - 1);
                q.push_back(r);
            end
            m_halted = 1;
        end
    endtask

    // Compare loop: entered and left at posedge+1
    task automatic run_queue();
        cyc_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            Start = r.start; Ack = r.ack; MemWrEn = r.memwr; LoadInst = r.load;
            BranchEn = r.br; RegWrEn = r.regwr; BranchTaken = r.taken; MemReady = r.mrdy;
            @(negedge Clk);
            chk("PcClear", 32'(PcClear), 32'(r.e_pcclr));
            chk("IrLoad", 32'(IrLoad), 32'(r.e_ir));
            chk("PcEn", 32'(PcEn), 32'(r.e_pcen));
            chk("PcLoadTarget", 32'(PcLoadTarget), 32'(r.e_plt));
            chk("RegWrStrobe", 32'(RegWrStrobe), 32'(r.e_rw));
            chk("MemReq", 32'(MemReq), 32'(r.e_mreq));
            chk("MemWe", 32'(MemWe), 32'(r.e_mwe));
            chk("Busy", 32'(Busy), 32'(r.e_busy));
            chk("Done", 32'(Done), 32'(r.e_done));
            chk("Error", 32'(Error), 32'(merr));
            chk("CycleCount", 32'(CycleCount), mcyc);
            chk("InstCount", 32'(InstCount), minst);
            if (MemReq) t_memreq++;
            if (RegWrStrobe) t_rw++;
            if (PcEn) t_pcen++;
            if (PcLoadTarget) t_plt++;
            if (PcClear) t_pcclr++;
            if (r.clr) begin
                merr = 0; mcyc = 0; minst = 0;
            end else begin
                if (r.e_busy && mcyc < CMAX) mcyc++;
                if (r.e_pcen && minst < CMAX) minst++;
            end
            if (r.to_err) merr = 1;
            @(posedge Clk);
            #1;
            step++;
        end
        Start = 0;
    endtask

    initial begin
        Reset_n = 0; Start = 1; Ack = 0; MemWrEn = 0; LoadInst = 0; BranchEn = 0;
        RegWrEn = 0; BranchTaken = 0; MemReady = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_PcClear", 32'(PcClear), 0);
        chk("rst_Busy", 32'(Busy), 0);
        chk("rst_Done", 32'(Done), 0);
        chk("rst_CycleCount", 32'(CycleCount), 0);
        Reset_n = 1;

        // ADD, ADD, halt
        tally_clear();
        push_arm(); push_start();
        push_instr(K_ALU); push_instr(K_ALU); push_instr(K_HALT); push_idle(2);
        run_queue();
        chk("t1_CycleCount", 32'(CycleCount), 6);
        chk("t1_InstCount", 32'(InstCount), 2);
        chk("t1_writes", t_rw, 2);
        chk("t1_Done", 32'(Done), 1);
        chk("t1_PcClear", t_pcclr, 1);

        // store with 3 wait cycles
        tally_clear();
        push_start(); push_instr(K_ST, 3); push_instr(K_HALT); push_idle(1);
        run_queue();
        chk("t2_memreq_cycles", t_memreq, 4);
        chk("t2_pcen", t_pcen, 1);
        chk("t2_writes", t_rw, 0);

        // load completing in its first MEM cycle
        tally_clear();
        push_start(); push_instr(K_LD, 0); push_instr(K_HALT); push_idle(1);
        run_queue();
        chk("t3_memreq_cycles", t_memreq, 1);
        chk("t3_writes", t_rw, 1);
        chk("t3_CycleCount", 32'(CycleCount), 6);

        // taken branch, not-taken branch, non-writing ALU op
        tally_clear();
        push_start(); push_instr(K_BR, 0, 1); push_instr(K_BR, 0, 0); push_instr(K_NOP, 0, 1);
        push_instr(K_HALT); push_idle(1);
        run_queue();
        chk("t4_pcen", t_pcen, 3);
        chk("t4_target", t_plt, 1);
        chk("t4_writes", t_rw, 0);

        // load that never completes, then restart clears Error
        tally_clear();
        push_start(); push_instr(K_LDTO); push_idle(2);
        run_queue();
        chk("t5_Error", 32'(Error), 1);
        chk("t5_Done", 32'(Done), 1);
        chk("t5_memreq_cycles", t_memreq, 4);
        chk("t5_pcen", t_pcen, 0);
        push_start(); push_instr(K_ALU); push_instr(K_HALT); push_idle(1);
        run_queue();
        chk("t5_Error_cleared", 32'(Error), 0);

        // long program saturates the cycle counter
        push_start();
        for (int i = 0; i < 10; i++) push_instr(K_ALU);
        push_instr(K_HALT); push_idle(1);
        run_queue();
        chk("sat_CycleCount", 32'(CycleCount), 15);
        chk("sat_InstCount", 32'(InstCount), 10);

        // reset asserted while a load waits in MEM
        push_start(); push_instr(K_LDTO);
        repeat (MEM_TO - 1) void'(q.pop_back());
        m_halted = 0;
        run_queue();
        MemReady = 0;
        #1;
        chk("t6_MemReq_before", 32'(MemReq), 1);
        Reset_n = 0;
        #1;
        chk("t6_MemReq", 32'(MemReq), 0);
        chk("t6_MemWe", 32'(MemWe), 0);
        chk("t6_Busy", 32'(Busy), 0);
        chk("t6_CycleCount", 32'(CycleCount), 0);
        chk("t6_InstCount", 32'(InstCount), 0);
        @(posedge Clk);
        #1;
        Reset_n = 1;
        merr = 0; mcyc = 0; minst = 0; m_halted = 0;
        tally_clear();
        push_arm(); push_start(); push_instr(K_ALU); push_instr(K_HALT); push_idle(2);
        run_queue();
        chk("t6_writes", t_rw, 1);
        chk("t6_Done", 32'(Done), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
